// File: rtl/vend_ctrl.sv
// vend_ctrl: nickel/dime vending controller. Accumulates credit, vends one
// item at PRICE, then pays change one coin per GAP cycles. Coins are rejected
// while busy, when they would push credit above MAX_BAL, or when sold out.
// Optional stock tracking is enabled by defining VEND_STOCK_EN.
module vend_ctrl #(
    parameter int PRICE   = 30,
    parameter int N       = 7,
    parameter int MAX_BAL = 95,
    parameter int GAP     = 2,
    parameter int STOCK   = 8,
    parameter int SW      = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         nickel,
    input  logic         dime,
    input  logic         refund,
    input  logic         restock,
    output logic         vend,
    output logic         nickel_out,
    output logic         dime_out,
    output logic         coin_reject,
    output logic         busy,
    output logic [N-1:0] balance,
    output logic         sold_out
);

    localparam int NW = N + 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [N-1:0]  PRICE_N    = N'(PRICE);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(GAP - 1);

    typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

    state_t        state;
    logic [GW-1:0] gap_cnt;
    logic [NW-1:0] credit;
    logic [NW-1:0] sum;
    logic          coin_in;
    logic          fits;
    logic          can_vend;
    logic          pay_dime;
    logic [N-1:0]  pay_bal;

`ifdef VEND_STOCK_EN
    logic [SW-1:0] stock;
    assign sold_out = (stock == '0);
`else
    logic [SW-1:0] cfg_unused;
    assign sold_out   = 1'b0;
    assign cfg_unused = SW'(STOCK) ^ {SW{restock}};
`endif

    assign busy = (state != IDLE);

    // Credit of this cycle's coins, overflow guard and next change coin.
    always_comb begin
        credit = '0;
        if (nickel) credit = credit + NW'(5);
        if (dime)   credit = credit + NW'(10);
        coin_in  = nickel | dime;
        sum      = {1'b0, balance} + credit;
        fits     = (sum <= NW'(MAX_BAL));
        can_vend = ({1'b0, balance} >= NW'(PRICE)) && !sold_out;
        pay_dime = ({1'b0, balance} >= NW'(10));
        pay_bal  = pay_dime ? (balance - N'(10)) : (balance - N'(5));
    end

    // Controller FSM with registered pulse outputs. The first change coin is
    // issued on the edge that enters CHANGE, later ones when gap_cnt hits 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            balance     <= '0;
            gap_cnt     <= '0;
            vend        <= 1'b0;
            nickel_out  <= 1'b0;
            dime_out    <= 1'b0;
            coin_reject <= 1'b0;
`ifdef VEND_STOCK_EN
            stock       <= SW'(STOCK);
`endif
        end else begin
            vend        <= 1'b0;
            nickel_out  <= 1'b0;
            dime_out    <= 1'b0;
            coin_reject <= coin_in;
            case (state)
                IDLE: begin
                    if (refund && balance != '0) begin
                        state      <= CHANGE;
                        balance    <= pay_bal;
                        dime_out   <= pay_dime;
                        nickel_out <= !pay_dime;
                        gap_cnt    <= GAP_RELOAD;
                    end else if (can_vend) begin
                        state   <= VEND;
                        vend    <= 1'b1;
                        balance <= balance - PRICE_N;
                    end else if (coin_in && fits && !sold_out) begin
                        balance     <= sum[N-1:0];
                        coin_reject <= 1'b0;
                    end
`ifdef VEND_STOCK_EN
                    if (restock) stock <= SW'(STOCK);
`endif
                end
                VEND: begin
`ifdef VEND_STOCK_EN
                    if (stock != '0) stock <= stock - SW'(1);
`endif
                    if (balance != '0) begin
                        state      <= CHANGE;
                        balance    <= pay_bal;
                        dime_out   <= pay_dime;
                        nickel_out <= !pay_dime;
                        gap_cnt    <= GAP_RELOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                CHANGE: begin
                    if (balance == '0) begin
                        state <= IDLE;
                    end else if (gap_cnt == '0) begin
                        balance    <= pay_bal;
                        dime_out   <= pay_dime;
                        nickel_out <= !pay_dime;
                        gap_cnt    <= GAP_RELOAD;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed testbench for vend_ctrl: default instance (PRICE=30, MAX_BAL=95,
// GAP=2, STOCK=8) and a second instance with PRICE=90, MAX_BAL=90, STOCK=1.
module tb_vend_ctrl;

`ifdef VEND_STOCK_EN
    localparam bit STOCK_ON = 1'b1;
`else
    localparam bit STOCK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, nickel, dime, refund, restock;
    logic a_vend, a_nout, a_dout, a_rej, a_busy, a_sold;
    logic b_vend, b_nout, b_dout, b_rej, b_busy, b_sold;
    logic [6:0] a_bal, b_bal;

    int total = 0;
    int bad   = 0;

    vend_ctrl dut_a (
        .clk(clk), .reset(reset), .nickel(nickel), .dime(dime),
        .refund(refund), .restock(restock), .vend(a_vend),
        .nickel_out(a_nout), .dime_out(a_dout), .coin_reject(a_rej),
        .busy(a_busy), .balance(a_bal), .sold_out(a_sold)
    );

    vend_ctrl #(.PRICE(90), .MAX_BAL(90), .STOCK(1)) dut_b (
        .clk(clk), .reset(reset), .nickel(nickel), .dime(dime),
        .refund(refund), .restock(restock), .vend(b_vend),
        .nickel_out(b_nout), .dime_out(b_dout), .coin_reject(b_rej),
        .busy(b_busy), .balance(b_bal), .sold_out(b_sold)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        nickel = 1'b0; dime = 1'b0; refund = 1'b0; restock = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_in();
        dime = 1'b1;
        step(); step();
        do_reset();
        total++;
        if ({a_vend, a_nout, a_dout, a_rej, a_busy, a_sold} !== 6'b0) begin
            bad++; $display("FAIL reset_outs got=%b want=000000", {a_vend, a_nout, a_dout, a_rej, a_busy, a_sold});
        end
        total++;
        if (a_bal !== 7'd0) begin bad++; $display("FAIL reset_bal got=%0d want=0", a_bal); end
        total++;
        if ({b_busy, b_sold} !== 2'b00) begin bad++; $display("FAIL reset_b got=%b want=00", {b_busy, b_sold}); end
    endtask

    task automatic test_three_dimes();
        do_reset();
        dime = 1'b1;
        step();
        total++; if (a_bal !== 7'd10) begin bad++; $display("FAIL dimes_bal1 got=%0d want=10", a_bal); end
        step();
        total++; if (a_bal !== 7'd20) begin bad++; $display("FAIL dimes_bal2 got=%0d want=20", a_bal); end
        step();
        total++;
        if ({a_bal, a_vend, a_busy, a_rej} !== {7'd30, 3'b000}) begin
            bad++; $display("FAIL dimes_bal3 got bal=%0d vend=%b busy=%b rej=%b want 30/0/0/0", a_bal, a_vend, a_busy, a_rej);
        end
        // nickel in the transition cycle must bounce
        dime = 1'b0; nickel = 1'b1;
        step();
        nickel = 1'b0;
        total++;
        if ({a_bal, a_vend, a_busy, a_rej} !== {7'd0, 3'b111}) begin
            bad++; $display("FAIL dimes_vend got bal=%0d vend=%b busy=%b rej=%b want 0/1/1/1", a_bal, a_vend, a_busy, a_rej);
        end
        step();
        total++;
        if ({a_bal, a_vend, a_busy, a_nout, a_dout, a_rej} !== {7'd0, 5'b00000}) begin
            bad++; $display("FAIL dimes_after got bal=%0d outs=%b want 0/00000", a_bal, {a_vend, a_busy, a_nout, a_dout, a_rej});
        end
    endtask

    task automatic test_combo();
        do_reset();
        dime = 1'b1;
        step(); step();
        total++; if (a_bal !== 7'd20) begin bad++; $display("FAIL combo_bal20 got=%0d want=20", a_bal); end
        nickel = 1'b1;
        step();
        nickel = 1'b0; dime = 1'b0;
        total++; if (a_bal !== 7'd35) begin bad++; $display("FAIL combo_bal35 got=%0d want=35", a_bal); end
        step();
        total++;
        if ({a_bal, a_vend, a_busy} !== {7'd5, 2'b11}) begin
            bad++; $display("FAIL combo_vend got bal=%0d vend=%b busy=%b want 5/1/1", a_bal, a_vend, a_busy);
        end
        dime = 1'b1;
        step();
        dime = 1'b0;
        total++;
        if ({a_bal, a_nout, a_dout, a_rej, a_vend} !== {7'd0, 4'b1010}) begin
            bad++; $display("FAIL combo_change got bal=%0d n=%b d=%b rej=%b vend=%b want 0/1/0/1/0", a_bal, a_nout, a_dout, a_rej, a_vend);
        end
        step();
        total++;
        if ({a_bal, a_busy, a_nout, a_dout, a_rej} !== {7'd0, 4'b0000}) begin
            bad++; $display("FAIL combo_idle got bal=%0d busy=%b n=%b d=%b rej=%b want 0/0/0/0/0", a_bal, a_busy, a_nout, a_dout, a_rej);
        end
    endtask

    task automatic test_refund();
        int ed[6] = '{1, 0, 1, 0, 0, 0};
        int en[6] = '{0, 0, 0, 0, 1, 0};
        int eb[6] = '{15, 15, 5, 5, 0, 0};
        int ey[6] = '{1, 1, 1, 1, 1, 0};
        do_reset();
        refund = 1'b1;
        step();
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL refund_zero got busy=%b want=0", a_busy); end
        refund = 1'b0; dime = 1'b1;
        step(); step();
        dime = 1'b0; nickel = 1'b1;
        step();
        nickel = 1'b0;
        total++; if (a_bal !== 7'd25) begin bad++; $display("FAIL refund_bal25 got=%0d want=25", a_bal); end
        // refund held high throughout: ignored once CHANGE is entered
        refund = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            total++;
            if (a_dout !== ed[k][0] || a_nout !== en[k][0] || a_bal !== 7'(eb[k]) || a_busy !== ey[k][0]) begin
                bad++;
                $display("FAIL refund_seq%0d got d=%b n=%b bal=%0d busy=%b want d=%0d n=%0d bal=%0d busy=%0d",
                         k, a_dout, a_nout, a_bal, a_busy, ed[k], en[k], eb[k], ey[k]);
            end
        end
        step();
        refund = 1'b0;
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL refund_rest got busy=%b want=0", a_busy); end
    endtask

    task automatic test_reset_mid();
        // reset in the VEND cycle: pending nickel change is lost
        do_reset();
        dime = 1'b1;
        step(); step();
        nickel = 1'b1;
        step();
        idle_in();
        step();
        total++; if (a_vend !== 1'b1) begin bad++; $display("FAIL rstmid_vend got=%b want=1", a_vend); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if ({a_bal, a_busy, a_nout, a_dout, a_vend} !== {7'd0, 4'b0000}) begin
            bad++; $display("FAIL rstmid_vend_clr got bal=%0d busy=%b n=%b d=%b v=%b want 0/0/0/0/0", a_bal, a_busy, a_nout, a_dout, a_vend);
        end
        // reset during CHANGE after the first refund coin
        do_reset();
        dime = 1'b1;
        step(); step();
        dime = 1'b0; nickel = 1'b1;
        step();
        nickel = 1'b0; refund = 1'b1;
        step();
        refund = 1'b0;
        total++; if (a_dout !== 1'b1) begin bad++; $display("FAIL rstmid_coin1 got=%b want=1", a_dout); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if ({a_bal, a_busy} !== {7'd0, 1'b0}) begin
            bad++; $display("FAIL rstmid_chg_clr got bal=%0d busy=%b want 0/0", a_bal, a_busy);
        end
        for (int k = 0; k < 5; k++) begin
            total++;
            if ({a_nout, a_dout, a_busy} !== 3'b000) begin
                bad++; $display("FAIL rstmid_quiet%0d got n=%b d=%b busy=%b want 000", k, a_nout, a_dout, a_busy);
            end
            step();
        end
    endtask

    task automatic test_overflow();
        do_reset();
        dime = 1'b1;
        repeat (8) step();
        total++; if (b_bal !== 7'd80) begin bad++; $display("FAIL ovf_bal80 got=%0d want=80", b_bal); end
        dime = 1'b0; nickel = 1'b1;
        step();
        total++; if (b_bal !== 7'd85) begin bad++; $display("FAIL ovf_bal85 got=%0d want=85", b_bal); end
        dime = 1'b1;
        step();
        total++;
        if ({b_bal, b_rej} !== {7'd85, 1'b1}) begin
            bad++; $display("FAIL ovf_both got bal=%0d rej=%b want 85/1", b_bal, b_rej);
        end
        nickel = 1'b0;
        step();
        total++;
        if ({b_bal, b_rej} !== {7'd85, 1'b1}) begin
            bad++; $display("FAIL ovf_dime got bal=%0d rej=%b want 85/1", b_bal, b_rej);
        end
        dime = 1'b0; nickel = 1'b1;
        step();
        nickel = 1'b0;
        total++;
        if ({b_bal, b_rej, b_vend} !== {7'd90, 2'b00}) begin
            bad++; $display("FAIL ovf_nickel got bal=%0d rej=%b vend=%b want 90/0/0", b_bal, b_rej, b_vend);
        end
        step();
        total++;
        if ({b_bal, b_vend} !== {7'd0, 1'b1}) begin
            bad++; $display("FAIL ovf_vend got bal=%0d vend=%b want 0/1", b_bal, b_vend);
        end
        step();
        total++;
        if ({b_busy, b_vend, b_sold} !== {2'b00, STOCK_ON}) begin
            bad++; $display("FAIL ovf_after got busy=%b vend=%b sold=%b want 0/0/%b", b_busy, b_vend, b_sold, STOCK_ON);
        end
    endtask

    task automatic test_sold_out();
        // continues from test_overflow: dut_b has just vended its only item
        dime = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (b_rej !== STOCK_ON || b_bal !== (STOCK_ON ? 7'd0 : 7'(10 * (k + 1)))) begin
                bad++; $display("FAIL sold_dime%0d got rej=%b bal=%0d want rej=%b bal=%0d",
                                k, b_rej, b_bal, STOCK_ON, STOCK_ON ? 0 : 10 * (k + 1));
            end
        end
        dime = 1'b0; restock = 1'b1;
        step();
        restock = 1'b0;
        total++; if (b_sold !== 1'b0) begin bad++; $display("FAIL sold_restock got=%b want=0", b_sold); end
        nickel = 1'b1;
        step();
        nickel = 1'b0;
        total++;
        if ({b_bal, b_rej} !== {(STOCK_ON ? 7'd5 : 7'd35), 1'b0}) begin
            bad++; $display("FAIL sold_accept got bal=%0d rej=%b want %0d/0", b_bal, b_rej, STOCK_ON ? 5 : 35);
        end
    endtask

    initial begin
        idle_in();
        reset = 1'b0;
        test_reset();
        test_three_dimes();
        test_combo();
        test_refund();
        test_reset_mid();
        test_overflow();
        test_sold_out();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
